// File: rtl/fixed_point_multiplier_if.sv
// Operand load / start handshake and result bus
// for the Q6.4 sequential multiplier.
interface fixed_point_multiplier_if #(
  parameter int WIDTH = 10
);
  logic             ld_a;
  logic             ld_b;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             start;
  logic [WIDTH-1:0] p;
  logic             ov;
  logic             busy;
  logic             done;

  modport master (
    output ld_a, ld_b, A, B, start,
    input  p, ov, busy, done
  );

  modport slave (
    input  ld_a, ld_b, A, B, start,
    output p, ov, busy, done
  );
endinterface

// File: rtl/fixed_point_multiplier.sv
// Sequential unsigned Q6.4 shift-and-add multiplier,
// one multiplier bit per clock, truncated result.
module fixed_point_multiplier #(
  parameter int WIDTH = 10,
  parameter int FRAC  = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  fixed_point_multiplier_if.slave bus
);
  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t           state;
  state_t           state_nx;
  logic [WIDTH-1:0] local_a;
  logic [WIDTH-1:0] local_b;
  logic [WIDTH-1:0] mcand;
  logic [WIDTH:0]   acc;
  logic [WIDTH-1:0] mq;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] p_q;
  logic             ov_q;
  logic [WIDTH:0]   sum;
  logic [2*WIDTH:0] shifted;
  logic             last;

  assign bus.busy = (state == RUN);
  assign bus.done = (state == DONE);
  assign bus.p    = p_q;
  assign bus.ov   = ov_q;

  // One add-and-shift step; shifted[2W-1:0] is the
  // full product once the last step has run.
  always_comb begin
    sum     = acc + ({1'b0, mcand} &
                     {(WIDTH+1){mq[0]}});
    shifted = {sum, mq} >> 1;
    last    = (cnt == CW'(WIDTH-1));
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  // Next-state decode.
  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (bus.start) state_nx = RUN;
      RUN:     if (last) state_nx = DONE;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Operand capture, iteration datapath and
  // result registers. mcand snapshots local_a at
  // start so a load in the start cycle cannot
  // disturb the running multiply.
  always_ff @(posedge clk) begin
    if (rst) begin
      local_a <= '0;
      local_b <= '0;
      mcand   <= '0;
      acc     <= '0;
      mq      <= '0;
      cnt     <= '0;
      p_q     <= '0;
      ov_q    <= 1'b0;
    end else begin
      if (state != RUN) begin
        if (bus.ld_a) local_a <= bus.A;
        if (bus.ld_b) local_b <= bus.B;
      end
      if (state == IDLE && bus.start) begin
        acc   <= '0;
        mq    <= local_b;
        mcand <= local_a;
        cnt   <= '0;
      end
      if (state == RUN) begin
        acc <= shifted[2*WIDTH:WIDTH];
        mq  <= shifted[WIDTH-1:0];
        cnt <= cnt + CW'(1);
        if (last) begin
          p_q  <= shifted[WIDTH+FRAC-1:FRAC];
          ov_q <= |shifted[2*WIDTH-1:WIDTH+FRAC];
        end
      end
    end
  end
endmodule
